// File: rtl/fetch_pkg.sv
// Shared constants and the buffer entry type for the instruction fetch slice.
package fetch_pkg;

   // imem word-address width (4096-word imem by default)
   localparam int ADDR_W = 12;

   // Instruction buffer entries
   localparam int DEPTH = 2;

   // Program counter width
   localparam int PC_W = 32;

   // Instruction word width
   localparam int INSTR_W = 32;

   // Value presented on instr_out before anything has been fetched
   localparam logic [INSTR_W-1:0] NOP = 32'h0;

   // One buffered instruction together with the PC it was fetched from
   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   // Contents of the head register out of reset
   localparam fetch_entry_t EMPTY_ENTRY = '{pc: '0, instr: NOP};

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction buffer of {pc, instr} entries. Supports push and pop in
// the same cycle and a synchronous clear. The head entry is presented from a
// register, so the outputs keep their last value once the buffer drains.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = fetch_pkg::DEPTH
)
(
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       clear,
   input  logic                       push,
   input  fetch_entry_t               push_data,
   input  logic                       pop,
   output fetch_entry_t               head,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] LAST_SLOT = PW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   fetch_entry_t     entry_reg [DEPTH];
   logic [PW-1:0]    wr_ptr_reg;
   logic [PW-1:0]    wr_ptr_next;
   logic [PW-1:0]    rd_ptr_reg;
   logic [PW-1:0]    rd_ptr_next;
   logic [CW-1:0]    count_reg;
   logic [CW-1:0]    count_next;
   fetch_entry_t     head_reg;
   fetch_entry_t     head_next;
   logic             do_push;
   logic             do_pop;

   // Pointer, occupancy and head selection for the coming cycle.
   always_comb begin
      do_pop      = pop && (count_reg != '0) && !clear;
      // A push into a full buffer is only legal when a pop frees a slot.
      do_push     = push && !clear && ((count_reg != FULL_COUNT) || do_pop);
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;
      head_next   = head_reg;

      if (clear) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
         count_next  = '0;
      end else begin
         if (do_push) begin
            wr_ptr_next = (wr_ptr_reg == LAST_SLOT) ? '0 : wr_ptr_reg + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_next = (rd_ptr_reg == LAST_SLOT) ? '0 : rd_ptr_reg + 1'b1;
         end
         count_next = count_reg + CW'(do_push) - CW'(do_pop);

         // When the new head is the slot being written this cycle it has to
         // come from the push data; the array still holds stale contents.
         if (count_next != '0) begin
            if (do_push && (wr_ptr_reg == rd_ptr_next)) begin
               head_next = push_data;
            end else begin
               head_next = entry_reg[rd_ptr_next];
            end
         end
      end
   end

   // Entry storage: plain array write, no reset needed on the data.
   always_ff @(posedge clock) begin
      if (do_push) begin
         entry_reg[wr_ptr_reg] <= push_data;
      end
   end

   // Control state and registered head entry.
   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         head_reg   <= EMPTY_ENTRY;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
         head_reg   <= head_next;
      end
   end

   assign head  = head_reg;
   assign count = count_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one imem read per cycle while the buffer has
// room for the result, tags each returning word with its PC, and flushes on a
// redirect. imem has a fixed one-cycle read latency, so at most one request
// is ever in flight.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int ADDR_W = fetch_pkg::ADDR_W,
   parameter int DEPTH  = fetch_pkg::DEPTH
)
(
   input  logic                clock,
   input  logic                reset,
   output logic                imem_rden,
   output logic [ADDR_W-1:0]   imem_addr,
   input  logic [INSTR_W-1:0]  imem_q,
   output logic                instr_valid,
   input  logic                instr_ready,
   output logic [INSTR_W-1:0]  instr_out,
   output logic [PC_W-1:0]     pc_out,
   input  logic                redirect,
   input  logic [PC_W-1:0]     redirect_pc
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW:0] DEPTH_LIMIT = (CW+1)'(DEPTH);

   logic [PC_W-1:0]  fetch_pc_reg;
   logic [PC_W-1:0]  fetch_pc_next;
   logic             inflight_reg;
   logic             inflight_next;
   logic [PC_W-1:0]  inflight_pc_reg;
   logic [PC_W-1:0]  inflight_pc_next;

   logic [CW-1:0]    fifo_count;
   fetch_entry_t     fifo_head;
   fetch_entry_t     fifo_push_data;
   logic             deq;
   logic             issue;
   logic [CW:0]      occupancy;

   // Issue decision and next fetch state. A redirect suppresses both the
   // issue and the dequeue of this cycle; the buffer is cleared instead.
   always_comb begin
      deq       = instr_valid && instr_ready && !redirect;
      // Slots that will be committed after this cycle: buffered entries plus
      // the word arriving now, less the one handed to the processor.
      occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_reg} - {{CW{1'b0}}, deq};
      issue     = reset && !redirect && (occupancy < DEPTH_LIMIT);

      fetch_pc_next    = fetch_pc_reg;
      inflight_next    = issue;
      inflight_pc_next = inflight_pc_reg;

      if (redirect) begin
         fetch_pc_next = redirect_pc;
      end else if (issue) begin
         fetch_pc_next    = fetch_pc_reg + 1'b1;
         inflight_pc_next = fetch_pc_reg;
      end
   end

   // Fetch PC and the single outstanding-request tracker.
   always_ff @(posedge clock) begin
      if (!reset) begin
         fetch_pc_reg    <= '0;
         inflight_reg    <= 1'b0;
         inflight_pc_reg <= '0;
      end else begin
         fetch_pc_reg    <= fetch_pc_next;
         inflight_reg    <= inflight_next;
         inflight_pc_reg <= inflight_pc_next;
      end
   end

   assign fifo_push_data = '{pc: inflight_pc_reg, instr: imem_q};

   // The buffer drops the arriving word itself when cleared by a redirect.
   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .clear     (redirect),
      .push      (inflight_reg),
      .push_data (fifo_push_data),
      .pop       (deq),
      .head      (fifo_head),
      .count     (fifo_count)
   );

   assign imem_rden   = issue;
   assign imem_addr   = fetch_pc_reg[ADDR_W-1:0];
   assign instr_valid = (fifo_count != '0);
   assign instr_out   = fifo_head.instr;
   assign pc_out      = fifo_head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a per-cycle vector table checks the imem request and
// the presented instruction, while a scoreboard checks every transfer.
module tb_fetch_unit;

   localparam int ADDR_W = 12;

   logic              clock;
   logic              reset;
   logic              imem_rden;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_q;
   logic              instr_valid;
   logic              instr_ready;
   logic [31:0]       instr_out;
   logic [31:0]       pc_out;
   logic              redirect;
   logic [31:0]       redirect_pc;

   typedef struct {
      bit                rst;
      bit                rdy;
      bit                rdr;
      logic [31:0]       rpc;
      bit                chk;
      bit                rden;
      logic [ADDR_W-1:0] addr;
      bit                valid;
      logic [31:0]       pc;
      logic [31:0]       instr;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   vec_t vec[$];
   exp_t sb[$];
   int   checks    = 0;
   int   failures  = 0;
   int   transfers = 0;
   bit   prev_rst  = 1'b0;

   fetch_unit #(
      .ADDR_W (ADDR_W),
      .DEPTH  (2)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .imem_rden   (imem_rden),
      .imem_addr   (imem_addr),
      .imem_q      (imem_q),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr_out   (instr_out),
      .pc_out      (pc_out),
      .redirect    (redirect),
      .redirect_pc (redirect_pc)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // imem contents: word k holds k + 0x100
   function automatic logic [31:0] imem_word(input logic [31:0] pc);
      return 32'(pc[ADDR_W-1:0]) + 32'h100;
   endfunction

   task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s row=%0d got=%h expected=%h", name, row, act, exp);
      end
   endtask

   task automatic add(input bit rst, input bit rdy, input bit rdr, input logic [31:0] rpc,
                      input bit chk, input bit rden, input logic [ADDR_W-1:0] addr,
                      input bit valid, input logic [31:0] pc, input logic [31:0] instr);
      vec_t v;
      v.rst = rst; v.rdy = rdy; v.rdr = rdr; v.rpc = rpc; v.chk = chk;
      v.rden = rden; v.addr = addr; v.valid = valid; v.pc = pc; v.instr = instr;
      vec.push_back(v);
   endtask

   // Expected transfer stream after a restart at pc 'start'
   task automatic push_stream(input logic [31:0] start);
      sb.delete();
      for (int k = 0; k < 32; k++) begin
         exp_t e;
         e.pc    = start + 32'(k);
         e.instr = imem_word(e.pc);
         sb.push_back(e);
      end
   endtask

   // Transfer monitor: one scoreboard pop per accepted instruction
   always @(negedge clock) begin
      exp_t e;
      if (reset === 1'b1 && redirect === 1'b0 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
         transfers++;
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL xfer_unexpected n=%0d got_pc=%h expected=none", transfers, pc_out);
         end else begin
            e = sb.pop_front();
            check("xfer_pc", transfers, pc_out, e.pc);
            check("xfer_instr", transfers, instr_out, e.instr);
            $display("xfer %0d pc=%h instr=%h", transfers, pc_out, instr_out);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic              rd;
      logic [ADDR_W-1:0] ad;
      vec_t              v;

      reset       = 1'b0;
      instr_ready = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      imem_q      = 32'hDEADBEEF;

      //   rst rdy rdr rpc        chk rden addr     vld pc          instr
      // reset
      add(0, 1, 0, 32'h0,      0,  0, 12'h000, 0, 32'h0,      32'h0);
      add(0, 1, 0, 32'h0,      1,  0, 12'h000, 0, 32'h0,      32'h0);
      // streaming start, latency 2, one per cycle
      add(1, 1, 0, 32'h0,      1,  1, 12'h000, 0, 32'h0,      32'h0);
      add(1, 1, 0, 32'h0,      1,  1, 12'h001, 0, 32'h0,      32'h0);
      add(1, 1, 0, 32'h0,      1,  1, 12'h002, 1, 32'h0,      32'h100);
      add(1, 1, 0, 32'h0,      1,  1, 12'h003, 1, 32'h1,      32'h101);
      add(1, 1, 0, 32'h0,      1,  1, 12'h004, 1, 32'h2,      32'h102);
      // redirect while a transfer is offered
      add(1, 1, 1, 32'h80,     1,  0, 12'h005, 1, 32'h3,      32'h103);
      add(1, 1, 0, 32'h0,      1,  1, 12'h080, 0, 32'h3,      32'h103);
      add(1, 1, 0, 32'h0,      1,  1, 12'h081, 0, 32'h3,      32'h103);
      add(1, 1, 0, 32'h0,      1,  1, 12'h082, 1, 32'h80,     32'h180);
      add(1, 1, 0, 32'h0,      1,  1, 12'h083, 1, 32'h81,     32'h181);
      // reset mid-stream
      add(0, 1, 0, 32'h0,      1,  0, 12'h084, 1, 32'h82,     32'h182);
      add(0, 1, 0, 32'h0,      1,  0, 12'h000, 0, 32'h0,      32'h0);
      // stall with a full buffer, then resume
      add(1, 1, 0, 32'h0,      1,  1, 12'h000, 0, 32'h0,      32'h0);
      add(1, 1, 0, 32'h0,      1,  1, 12'h001, 0, 32'h0,      32'h0);
      add(1, 1, 0, 32'h0,      1,  1, 12'h002, 1, 32'h0,      32'h100);
      add(1, 0, 0, 32'h0,      1,  0, 12'h003, 1, 32'h1,      32'h101);
      add(1, 0, 0, 32'h0,      1,  0, 12'h003, 1, 32'h1,      32'h101);
      add(1, 0, 0, 32'h0,      1,  0, 12'h003, 1, 32'h1,      32'h101);
      add(1, 0, 0, 32'h0,      1,  0, 12'h003, 1, 32'h1,      32'h101);
      add(1, 0, 0, 32'h0,      1,  0, 12'h003, 1, 32'h1,      32'h101);
      add(1, 1, 0, 32'h0,      1,  1, 12'h003, 1, 32'h1,      32'h101);
      add(1, 1, 0, 32'h0,      1,  1, 12'h004, 1, 32'h2,      32'h102);
      // redirect with one buffered entry and one word in flight
      add(1, 0, 1, 32'h40,     1,  0, 12'h005, 1, 32'h3,      32'h103);
      add(1, 1, 0, 32'h0,      1,  1, 12'h040, 0, 32'h3,      32'h103);
      add(1, 1, 0, 32'h0,      1,  1, 12'h041, 0, 32'h3,      32'h103);
      add(1, 1, 0, 32'h0,      1,  1, 12'h042, 1, 32'h40,     32'h140);
      add(1, 1, 0, 32'h0,      1,  1, 12'h043, 1, 32'h41,     32'h141);
      // single-cycle reset mid-stream, restart from pc 0
      add(0, 1, 0, 32'h0,      1,  0, 12'h044, 1, 32'h42,     32'h142);
      add(1, 1, 0, 32'h0,      1,  1, 12'h000, 0, 32'h0,      32'h0);
      add(1, 1, 0, 32'h0,      1,  1, 12'h001, 0, 32'h0,      32'h0);
      add(1, 1, 0, 32'h0,      1,  1, 12'h002, 1, 32'h0,      32'h100);
      add(1, 1, 0, 32'h0,      1,  1, 12'h003, 1, 32'h1,      32'h101);
      // redirect to the top of imem: address wraps, pc does not
      add(1, 1, 1, 32'hFFF,    1,  0, 12'h004, 1, 32'h2,      32'h102);
      add(1, 1, 0, 32'h0,      1,  1, 12'hFFF, 0, 32'h2,      32'h102);
      add(1, 1, 0, 32'h0,      1,  1, 12'h000, 0, 32'h2,      32'h102);
      add(1, 1, 0, 32'h0,      1,  1, 12'h001, 1, 32'hFFF,    32'h10FF);
      add(1, 1, 0, 32'h0,      1,  1, 12'h002, 1, 32'h1000,   32'h100);
      // back-to-back redirects: the second one wins
      add(1, 1, 1, 32'h200,    1,  0, 12'h003, 1, 32'h1001,   32'h101);
      add(1, 1, 1, 32'h300,    1,  0, 12'h200, 0, 32'h1001,   32'h101);
      add(1, 1, 0, 32'h0,      1,  1, 12'h300, 0, 32'h1001,   32'h101);
      add(1, 1, 0, 32'h0,      1,  1, 12'h301, 0, 32'h1001,   32'h101);
      add(1, 1, 0, 32'h0,      1,  1, 12'h302, 1, 32'h300,    32'h400);
      add(1, 1, 0, 32'h0,      1,  1, 12'h303, 1, 32'h301,    32'h401);

      for (int i = 0; i < vec.size(); i++) begin
         v = vec[i];
         reset       = v.rst;
         instr_ready = v.rdy;
         redirect    = v.rdr;
         redirect_pc = v.rpc;

         if (!v.rst) begin
            sb.delete();
         end else if (v.rdr) begin
            push_stream(v.rpc);
         end else if (!prev_rst) begin
            push_stream(32'h0);
         end
         prev_rst = v.rst;

         #1;
         if (v.chk) begin
            check("rden", i, imem_rden, v.rden);
            check("addr", i, imem_addr, v.addr);
            check("valid", i, instr_valid, v.valid);
            check("pc_out", i, pc_out, v.pc);
            check("instr_out", i, instr_out, v.instr);
         end
         $display("row %0d rst=%0b rdy=%0b rdr=%0b rden=%0b addr=%h valid=%0b pc=%h instr=%h",
                  i, v.rst, v.rdy, v.rdr, imem_rden, imem_addr, instr_valid, pc_out, instr_out);

         // imem model: read data appears one cycle after the request
         rd = imem_rden;
         ad = imem_addr;
         @(posedge clock);
         #1;
         imem_q = (rd === 1'b1) ? imem_word(32'(ad)) : 32'hDEADBEEF;
      end

      check("transfer_count", -1, transfers, 16);
      check("scoreboard_left", -1, sb.size(), 30);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
